alu_issue: RTL

Decode/issue stage that sits upstream of the ALU and is the producer of its `Operation`, `SrcB` immediate and operand-select controls. It accepts 32-bit RV32I instruction words on a valid/ready handshake, decodes them into the ALU operation code and register/immediate fields, and presents the decoded bundle to the execute stage through a registered output. Internal buffering is two entries: an output register plus a skid register. This lets both sides run at full throughput while keeping every handshake signal registered.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_decode.sv | 111 +++++++++++
 rtl/alu_issue.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: operation codes, instruction
// field encodings and the decoded bundle handed to the execute stage.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_XOR  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_SRAI = 4'b0111,
        OP_EQ   = 4'b1000,
        OP_SLLI = 4'b1001,
        OP_LUI  = 4'b1010,
        OP_SRLI = 4'b1100,
        OP_SLT  = 4'b1110
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e          op;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [XLEN-1:0]  imm;
        logic             alu_src;
        logic             reg_write;
        logic             branch;
        logic             illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I subset decoder: instruction word -> issue bundle.
// Register index fields are passed through raw for every encoding; illegal
// encodings carry a zero immediate and all control flags low except illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] in_instr,
    output issue_bundle_t   bundle
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;

    // Field extraction and immediate formats
    always_comb begin
        opc   = in_instr[6:0];
        f3    = in_instr[14:12];
        f7    = in_instr[31:25];
        imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
        imm_u = {in_instr[31:12], 12'b0};
    end

    // Opcode/funct decode into operation and control flags
    always_comb begin
        bundle         = '0;
        bundle.op      = OP_AND;
        bundle.rs1     = in_instr[19:15];
        bundle.rs2     = in_instr[24:20];
        bundle.rd      = in_instr[11:7];
        bundle.illegal = 1'b1;
        case (opc)
            OPC_RTYPE: begin
                bundle.reg_write = 1'b1;
                bundle.illegal   = 1'b0;
                if (f3 == F3_ADD && f7 == F7_BASE)      bundle.op = OP_ADD;
                else if (f3 == F3_ADD && f7 == F7_ALT)  bundle.op = OP_SUB;
                else if (f3 == F3_AND && f7 == F7_BASE) bundle.op = OP_AND;
                else if (f3 == F3_OR  && f7 == F7_BASE) bundle.op = OP_OR;
                else if (f3 == F3_XOR && f7 == F7_BASE) bundle.op = OP_XOR;
                else if (f3 == F3_SLT && f7 == F7_BASE) bundle.op = OP_SLT;
                else                                    bundle.illegal = 1'b1;
            end
            OPC_ITYPE: begin
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.imm       = imm_i;
                bundle.illegal   = 1'b0;
                // Shift immediates keep the whole I-field, so SRAI carries bit 10
                if (f3 == F3_ADD)                       bundle.op = OP_ADD;
                else if (f3 == F3_AND)                  bundle.op = OP_AND;
                else if (f3 == F3_OR)                   bundle.op = OP_OR;
                else if (f3 == F3_XOR)                  bundle.op = OP_XOR;
                else if (f3 == F3_SLT)                  bundle.op = OP_SLT;
                else if (f3 == F3_SLL && f7 == F7_BASE) bundle.op = OP_SLLI;
                else if (f3 == F3_SR  && f7 == F7_BASE) bundle.op = OP_SRLI;
                else if (f3 == F3_SR  && f7 == F7_ALT)  bundle.op = OP_SRAI;
                else                                    bundle.illegal = 1'b1;
            end
            OPC_LUI: begin
                bundle.op        = OP_LUI;
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.imm       = imm_u;
                bundle.illegal   = 1'b0;
            end
            OPC_LOAD: begin
                if (f3 == F3_WORD) begin
                    bundle.op        = OP_ADD;
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                    bundle.imm       = imm_i;
                    bundle.illegal   = 1'b0;
                end
            end
            OPC_STORE: begin
                if (f3 == F3_WORD) begin
                    bundle.op      = OP_ADD;
                    bundle.alu_src = 1'b1;
                    bundle.imm     = imm_s;
                    bundle.illegal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (f3 == F3_BEQ) begin
                    bundle.op      = OP_EQ;
                    bundle.branch  = 1'b1;
                    bundle.imm     = imm_b;
                    bundle.illegal = 1'b0;
                end
            end
            default: ;
        endcase
        // Any partially decoded illegal encoding collapses to a clean bundle
        if (bundle.illegal) begin
            bundle.op        = OP_AND;
            bundle.imm       = '0;
            bundle.alu_src   = 1'b0;
            bundle.reg_write = 1'b0;
            bundle.branch    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes accepted instructions and holds them in a
// two-entry buffer (output register + skid register) with all handshake
// outputs registered.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [DATA_WIDTH-1:0]    imm,
    output logic                     alu_src,
    output logic                     reg_write,
    output logic                     branch,
    output logic                     illegal
);

    issue_bundle_t dec_b;
    issue_bundle_t out_b;
    issue_bundle_t skid_b;
    logic          out_v;
    logic          skid_v;
    logic          rdy;
    logic          accept;
    logic          issue;
    logic          out_free;

    alu_decode u_decode (
        .in_instr (in_instr),
        .bundle   (dec_b)
    );

    // Handshake qualifiers for this cycle
    always_comb begin
        accept   = in_valid && rdy;
        issue    = out_v && out_ready;
        out_free = !out_v || issue;
    end

    // Two-entry buffer; rdy tracks !skid_v so in_ready comes from a flop.
    // An accept never coincides with a valid skid entry because rdy is low then.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b1;
            out_b  <= '0;
            skid_b <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b1;
        end else if (out_free) begin
            if (skid_v) begin
                out_b  <= skid_b;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
                rdy    <= 1'b1;
            end else if (accept) begin
                out_b <= dec_b;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_b <= dec_b;
            skid_v <= 1'b1;
            rdy    <= 1'b0;
        end
    end

    // Output register drives the execute-stage interface directly
    always_comb begin
        in_ready  = rdy;
        out_valid = out_v;
        Operation = out_b.op;
        rs1       = out_b.rs1;
        rs2       = out_b.rs2;
        rd        = out_b.rd;
        imm       = out_b.imm;
        alu_src   = out_b.alu_src;
        reg_write = out_b.reg_write;
        branch    = out_b.branch;
        illegal   = out_b.illegal;
    end

endmodule
